uart_result_tx: RTL
===================

// Module: uart_result_tx
// PURPOSE
//  Output end of the UART calculator. Captures the ALU result/error pair on a
//  load strobe and transmits it to the host as a 3-byte 8N1 UART frame:
//  status byte, result[15:8], result[7:0]. Sits between the ALU and the TX pin,
//  opposite the command receiver that feeds opcode/op1/op2 into the ALU.
// PARAMETERS
//  CLKS_PER_BIT  434    clock cycles per UART bit (50 MHz / 115200); >= 2
//  STATUS_OK     8'h00  status byte sent when error = 0
//  STATUS_ERR    8'hEE  status byte sent when error = 1
// PORTS
//  clk     in   1   single system clock, all logic rising-edge
//  rst_n   in   1   asynchronous, active-low reset
//  load    in   1   capture request, sampled only in IDLE
//  result  in   16  signed ALU result, two's complement
//  error   in   1   ALU error flag (e.g. divide by zero)
//  tx      out  1   UART serial output, idle high
//  busy    out  1   high from the cycle after an accepted load until frame end
//  done    out  1   one-cycle pulse after the last stop bit
// BEHAVIOUR
//  - Reset (async, rst_n=0): tx=1, busy=0, done=0, state=IDLE, all counters 0.
//    Reset asserted mid-frame aborts immediately; tx returns high the same instant.
//  - States: IDLE -> START -> DATA -> STOP -> (START of next byte | IDLE).
//  - IDLE: tx=1. load=1 captures the three bytes on that edge:
//    byte0 = error ? STATUS_ERR : STATUS_OK
//    byte1 = error ? 8'h00 : result[15:8]; byte2 = error ? 8'h00 : result[7:0].
//    Next state START, byte index 0, busy=1 from the following cycle.
//  - START: tx=0 for exactly CLKS_PER_BIT cycles.
//  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit counter 0..7.
//  - STOP: tx=1 for CLKS_PER_BIT cycles. If byte index < 2: increment the index
//    and go to START with no idle gap. If byte index = 2: go to IDLE.
//  - Frame length: exactly 30*CLKS_PER_BIT cycles of START/DATA/STOP. Count them
//    from the first cycle after the accepting edge to the last stop-bit cycle.
//  - On the first IDLE cycle after the frame: done=1 for one cycle and busy=0.
//    A load in that same cycle is accepted, so frames run back-to-back.
//  - load while busy=1 is ignored: no capture, no queueing. result and error may
//    change freely after capture without affecting the frame in flight.
//  - The baud counter runs 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
//    Its width is $clog2(CLKS_PER_BIT). tx is driven from a register (no glitches).
//  - No sign extension or width conversion: result is sent as its 16 raw bits.
// TESTING  (bench uses CLKS_PER_BIT=4; a UART monitor decodes tx)
//  1. load with result=16'd20, error=0 -> bytes 00,00,14. done pulses exactly
//     120 cycles after the accepting edge.
//  2. load with result=-16'sd10 (5-15), error=0 -> bytes 00,FF,F6. The start bit
//     of the next byte follows each stop bit directly.
//  3. load with result=16'h1234, error=1 -> bytes EE,00,00.
//  4. load pulsed again at cycle 10 of a frame, with different result ->
//     only the first frame is sent and busy stays high throughout.
//  5. rst_n low at cycle 50 of a frame -> tx=1, busy=0 at once. After release,
//     a new load sends a complete, correct frame.
//  6. load held high continuously with result=16'h00FF -> consecutive frames
//     00,00,FF. Each new start bit comes 1 cycle after the done pulse.

Source files
------------

// File: rtl/uart_result_tx.sv
// Captures an ALU result/error pair on load and sends it as a 3-byte 8N1 UART frame:
// status byte, result[15:8], result[7:0].
module uart_result_tx #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter logic [7:0]  STATUS_OK    = 8'h00,
   parameter logic [7:0]  STATUS_ERR   = 8'hEE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] result,
   input  logic        error,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e           state_q, state_d;
   logic [BaudW-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [1:0]       idx_q, idx_d;
   logic [7:0]       byte0_q, byte0_d;
   logic [7:0]       byte1_q, byte1_d;
   logic [7:0]       byte2_q, byte2_d;
   logic             tx_q, tx_d;
   logic             done_q, done_d;
   logic [7:0]       cur_byte;
   logic             baud_last;

   assign baud_last = (baud_q == BaudLast);

   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      idx_d    = idx_q;
      byte0_d  = byte0_q;
      byte1_d  = byte1_q;
      byte2_d  = byte2_q;
      done_d   = 1'b0;
      cur_byte = byte2_d;
      tx_d     = 1'b1;

      unique case (state_q)
         StIdle: begin
            baud_d = '0;
            bit_d  = '0;
            if (load) begin
               byte0_d = error ? STATUS_ERR : STATUS_OK;
               byte1_d = error ? 8'h00 : result[15:8];
               byte2_d = error ? 8'h00 : result[7:0];
               idx_d   = 2'd0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = StData;
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end
         StData: begin
            if (baud_last) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end
         StStop: begin
            if (baud_last) begin
               baud_d = '0;
               if (idx_q == 2'd2) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else begin
                  // Next byte's start bit follows the stop bit with no idle gap.
                  idx_d   = idx_q + 2'd1;
                  state_d = StStart;
               end
            end else begin
               baud_d = baud_q + BaudW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      case (idx_d)
         2'd0:    cur_byte = byte0_d;
         2'd1:    cur_byte = byte1_d;
         default: cur_byte = byte2_d;
      endcase

      // tx is registered from the next-state view so the line changes on the bit boundary.
      case (state_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = cur_byte[bit_d];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         idx_q   <= '0;
         byte0_q <= '0;
         byte1_q <= '0;
         byte2_q <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         idx_q   <= idx_d;
         byte0_q <= byte0_d;
         byte1_q <= byte1_d;
         byte2_q <= byte2_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   assign tx   = tx_q;
   assign busy = (state_q != StIdle);
   assign done = done_q;

endmodule
